// File: rtl/spi_slave_pkg.sv
// Shared encodings for the parametrised SPI slave: command codes, FSM states
// and a helper for sizing the frame/timeout counter.
package spi_slave_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

    // One counter serves both the RECV bit count and the WAIT_TX timeout.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised shift register with parallel load; MSB_FIRST selects shifting
// toward the MSB (serial in at bit 0) or toward the LSB (serial in at the top).
module spi_shift_reg
    import spi_slave_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_left
                if (gi == 0) begin : g_in
                    assign shifted[gi] = ser_in;
                end else begin : g_mid
                    assign shifted[gi] = q_reg[gi-1];
                end
            end else begin : g_right
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted[gi] = ser_in;
                end else begin : g_mid
                    assign shifted[gi] = q_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_data;
        end else if (shift) begin
            q_reg <= shifted;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM: receives {cmd, payload} frames,
// answers read-data commands with DATA_W bits on MISO, and flags framing errors.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int PAYLOAD_W  = 8,
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 1,
    parameter int TX_TIMEOUT = 16,
    parameter int STRICT_RD  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [PAYLOAD_W+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic                 tx_valid,
    output logic                 frame_err
);

    localparam int FRAME_W = PAYLOAD_W + 2;
    localparam int CNT_W   = cnt_width(FRAME_W, TX_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TX_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               rd_addr_seen_reg, rd_addr_seen_next;
    logic               miso_reg, miso_next;
    logic [FRAME_W-1:0] rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic               frame_err_reg, frame_err_next;

    logic               rx_shift;
    logic [FRAME_W-2:0] rx_q;
    logic [FRAME_W-1:0] rx_raw;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [1:0]         rx_cmd;
    logic [FRAME_W-1:0] rx_word;

    logic               tx_load, tx_shift, tx_bit, tx_empty;
    logic [DATA_W:0]    tx_load_data;
    logic [DATA_W:0]    tx_q;

    // Only FRAME_W-1 bits are stored: the final bit is taken straight from MOSI
    // so rx_data can be loaded on the same edge that captures it.
    spi_shift_reg #(
        .WIDTH     (FRAME_W - 1),
        .MSB_FIRST (1'b1)
    ) u_rx_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .ser_in    (MOSI),
        .q         (rx_q)
    );

    assign rx_raw = {rx_q, MOSI};
    assign rx_cmd = rx_raw[FRAME_W-1 -: 2];

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_W; gi++) begin : g_payload
            if (MSB_FIRST != 0) begin : g_keep
                assign rx_payload[gi] = rx_raw[gi];
            end else begin : g_rev
                assign rx_payload[gi] = rx_raw[PAYLOAD_W-1-gi];
            end
        end
    endgenerate

    assign rx_word = {rx_cmd, rx_payload};

    // The tx register carries a marker bit behind the data; once only the
    // marker remains, every data bit has been shifted out.
    generate
        if (MSB_FIRST != 0) begin : g_tx_msb
            assign tx_load_data = {tx_data, 1'b1};
            assign tx_bit       = tx_q[DATA_W];
            assign tx_empty     = (tx_q == {1'b1, {DATA_W{1'b0}}});
        end else begin : g_tx_lsb
            assign tx_load_data = {1'b1, tx_data};
            assign tx_bit       = tx_q[0];
            assign tx_empty     = (tx_q == {{DATA_W{1'b0}}, 1'b1});
        end
    endgenerate

    spi_shift_reg #(
        .WIDTH     (DATA_W + 1),
        .MSB_FIRST (MSB_FIRST != 0)
    ) u_tx_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (tx_load_data),
        .shift     (tx_shift),
        .ser_in    (1'b0),
        .q         (tx_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            rd_addr_seen_reg <= 1'b0;
            miso_reg         <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            rd_addr_seen_reg <= rd_addr_seen_next;
            miso_reg         <= miso_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            frame_err_reg    <= frame_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        rd_addr_seen_next = rd_addr_seen_reg;
        miso_next         = 1'b0;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        frame_err_next    = 1'b0;
        rx_shift          = 1'b0;
        tx_load           = 1'b0;
        tx_shift          = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!SS_n) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    // A frame completed on the same edge SS_n rises still counts.
                    cnt_next = '0;
                    if (rx_cmd == CMD_RD_DATA && STRICT_RD != 0 && !rd_addr_seen_reg) begin
                        frame_err_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        rx_data_next  = rx_word;
                        rx_valid_next = 1'b1;
                        state_next    = (rx_cmd == CMD_RD_DATA) ? WAIT_TX : DONE;
                    end
                    if (rx_cmd == CMD_RD_ADDR) begin
                        rd_addr_seen_next = 1'b1;
                    end else if (rx_cmd == CMD_RD_DATA) begin
                        rd_addr_seen_next = 1'b0;
                    end
                    if (SS_n) begin
                        state_next = IDLE;
                    end
                end else if (SS_n) begin
                    frame_err_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_TX: begin
                if (SS_n) begin
                    frame_err_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else if (tx_valid) begin
                    tx_load    = 1'b1;
                    cnt_next   = '0;
                    state_next = SEND;
                end else if (cnt_reg == LAST_WAIT) begin
                    frame_err_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SEND: begin
                if (SS_n) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else if (tx_empty) begin
                    state_next = DONE;
                end else begin
                    miso_next = tx_bit;
                    tx_shift  = 1'b1;
                end
            end
            DONE: begin
                if (SS_n) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign MISO      = miso_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an MSB-first instance plus an LSB-first
// instance, selected by sel_lsb; inputs change on the falling edge.
module tb_spi_slave_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ss_n, mosi, tx_valid, sel_lsb;
    logic [7:0] tx_data;
    logic       ss_main, ss_lsb;
    logic       miso_m, miso_l, rv_m, rv_l, fe_m, fe_l;
    logic [9:0] rxd_m, rxd_l;
    logic       obs_miso, obs_rx_valid, obs_frame_err;
    logic [9:0] obs_rx_data;

    int         n_checks, n_pass, rv_cnt, fe_cnt;
    logic       miso_or;
    logic [7:0] miso_byte;

    assign ss_main       = sel_lsb ? 1'b1 : ss_n;
    assign ss_lsb        = sel_lsb ? ss_n : 1'b1;
    assign obs_miso      = sel_lsb ? miso_l : miso_m;
    assign obs_rx_valid  = sel_lsb ? rv_l : rv_m;
    assign obs_frame_err = sel_lsb ? fe_l : fe_m;
    assign obs_rx_data   = sel_lsb ? rxd_l : rxd_m;

    spi_slave_param #(
        .PAYLOAD_W(8), .DATA_W(8), .MSB_FIRST(1), .TX_TIMEOUT(16), .STRICT_RD(1)
    ) dut (
        .clk(clk), .rst(rst), .SS_n(ss_main), .MOSI(mosi), .MISO(miso_m),
        .rx_data(rxd_m), .rx_valid(rv_m), .tx_data(tx_data), .tx_valid(tx_valid),
        .frame_err(fe_m)
    );

    spi_slave_param #(
        .PAYLOAD_W(8), .DATA_W(8), .MSB_FIRST(0), .TX_TIMEOUT(16), .STRICT_RD(1)
    ) dut_lsb (
        .clk(clk), .rst(rst), .SS_n(ss_lsb), .MOSI(mosi), .MISO(miso_l),
        .rx_data(rxd_l), .rx_valid(rv_l), .tx_data(tx_data), .tx_valid(tx_valid),
        .frame_err(fe_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the rising edge, observe at the falling edge.
    task automatic edge1(input logic ss, input logic m, input logic tv);
        ss_n     = ss;
        mosi     = m;
        tx_valid = tv;
        @(posedge clk);
        @(negedge clk);
        if (obs_rx_valid)  rv_cnt++;
        if (obs_frame_err) fe_cnt++;
        if (obs_miso)      miso_or = 1'b1;
    endtask

    task automatic clear_stats();
        rv_cnt  = 0;
        fe_cnt  = 0;
        miso_or = 1'b0;
    endtask

    task automatic frame(input logic [9:0] v, input int nbits);
        edge1(1'b0, 1'b0, 1'b0);
        for (int i = 9; i > 9 - nbits; i--) begin
            edge1(1'b0, v[i], 1'b0);
        end
        $display("frame %03h (%0d bits) on %s", v, nbits, sel_lsb ? "lsb" : "msb");
    endtask

    task automatic release_ss();
        edge1(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel_lsb  = 1'b0;
        miso_byte = 8'h00;
        clear_stats();
        @(negedge clk);
        edge1(1'b1, 1'b0, 1'b0);
        edge1(1'b1, 1'b0, 1'b0);
        check("reset_miso",      32'(obs_miso),      32'd0);
        check("reset_rx_data",   32'(obs_rx_data),   32'd0);
        check("reset_rx_valid",  32'(obs_rx_valid),  32'd0);
        check("reset_frame_err", 32'(obs_frame_err), 32'd0);
        rst = 1'b0;
        release_ss();

        // Write address
        clear_stats();
        frame(10'b00_1010_0101, 10);
        check("wa_rx_data",  32'(obs_rx_data),  32'h0A5);
        check("wa_rx_valid", 32'(obs_rx_valid), 32'd1);
        edge1(1'b0, 1'b1, 1'b0);
        check("wa_pulse_len", 32'(obs_rx_valid), 32'd0);
        release_ss();
        check("wa_valid_count", rv_cnt, 32'd1);
        check("wa_no_err",      fe_cnt, 32'd0);
        check("wa_miso_quiet",  32'(miso_or), 32'd0);

        // Read address then read data with tx_valid on the 3rd wait cycle
        clear_stats();
        frame(10'b10_0000_1111, 10);
        check("ra_rx_data", 32'(obs_rx_data), 32'h20F);
        release_ss();
        frame(10'b11_0000_0000, 10);
        check("rd_rx_valid", 32'(obs_rx_valid), 32'd1);
        check("rd_rx_data",  32'(obs_rx_data),  32'h300);
        tx_data = 8'hC3;
        edge1(1'b0, 1'b0, 1'b0);
        edge1(1'b0, 1'b0, 1'b0);
        edge1(1'b0, 1'b0, 1'b1);
        check("rd_miso_idle", 32'(miso_or), 32'd0);
        miso_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            edge1(1'b0, 1'b0, 1'b0);
            miso_byte = {miso_byte[6:0], obs_miso};
        end
        check("rd_miso_seq", 32'(miso_byte), 32'hC3);
        edge1(1'b0, 1'b0, 1'b0);
        check("rd_miso_back0", 32'(obs_miso), 32'd0);
        release_ss();
        check("rd_no_err",      fe_cnt, 32'd0);
        check("rd_valid_count", rv_cnt, 32'd2);

        // Abort after 5 bits
        clear_stats();
        frame(10'b01_1111_0000, 5);
        edge1(1'b1, 1'b0, 1'b0);
        check("ab_frame_err",    32'(obs_frame_err), 32'd1);
        check("ab_no_valid",     rv_cnt, 32'd0);
        check("ab_rx_data_hold", 32'(obs_rx_data), 32'h300);

        // Read data with no preceding read address
        clear_stats();
        frame(10'b11_0101_0101, 10);
        check("st_frame_err",    32'(obs_frame_err), 32'd1);
        check("st_no_valid",     rv_cnt, 32'd0);
        check("st_rx_data_hold", 32'(obs_rx_data), 32'h300);
        release_ss();
        check("st_err_count", fe_cnt, 32'd1);

        // tx_valid never arrives: timeout on the 16th wait cycle
        clear_stats();
        frame(10'b10_0000_0001, 10);
        release_ss();
        frame(10'b11_0000_0000, 10);
        for (int k = 0; k < 15; k++) begin
            edge1(1'b0, 1'b0, 1'b0);
        end
        check("to_not_early", fe_cnt, 32'd0);
        edge1(1'b0, 1'b0, 1'b0);
        check("to_frame_err",   32'(obs_frame_err), 32'd1);
        check("to_valid_count", rv_cnt, 32'd2);
        release_ss();
        check("to_miso_quiet", 32'(miso_or), 32'd0);

        // LSB-first instance
        sel_lsb = 1'b1;
        clear_stats();
        frame(10'b01_1010_0000, 10);
        check("lsb_rx_data",  32'(obs_rx_data),  32'h105);
        check("lsb_rx_valid", 32'(obs_rx_valid), 32'd1);
        release_ss();
        frame(10'b10_0000_0000, 10);
        release_ss();
        frame(10'b11_0000_0000, 10);
        tx_data = 8'h01;
        edge1(1'b0, 1'b0, 1'b1);
        miso_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            edge1(1'b0, 1'b0, 1'b0);
            miso_byte[k] = obs_miso;
            if (k == 0) check("lsb_miso_first", 32'(obs_miso), 32'd1);
        end
        check("lsb_miso_seq", 32'(miso_byte), 32'h01);
        edge1(1'b0, 1'b0, 1'b0);
        check("lsb_miso_back0", 32'(obs_miso), 32'd0);
        release_ss();
        check("lsb_no_err", fe_cnt, 32'd0);

        // Reset in the middle of SEND
        sel_lsb = 1'b0;
        clear_stats();
        frame(10'b10_1010_1010, 10);
        release_ss();
        frame(10'b11_1111_1111, 10);
        check("rs_rx_data", 32'(obs_rx_data), 32'h3FF);
        tx_data = 8'hFF;
        edge1(1'b0, 1'b0, 1'b1);
        edge1(1'b0, 1'b0, 1'b0);
        edge1(1'b0, 1'b0, 1'b0);
        edge1(1'b0, 1'b0, 1'b0);
        check("rs_miso_sending", 32'(obs_miso), 32'd1);
        rst = 1'b1;
        edge1(1'b0, 1'b0, 1'b0);
        check("rs_miso_cleared",    32'(obs_miso),    32'd0);
        check("rs_rx_data_cleared", 32'(obs_rx_data), 32'd0);
        check("rs_no_err",          fe_cnt, 32'd0);
        rst = 1'b0;
        frame(10'b01_1100_0011, 10);
        check("post_rst_rx_data",  32'(obs_rx_data),  32'h1C3);
        check("post_rst_rx_valid", 32'(obs_rx_valid), 32'd1);
        release_ss();
        check("post_rst_no_err", fe_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
